softmax_seq: RTL and testbench
==============================

SOFTMAX_SEQ -- requirements
Module: softmax_seq

Interface
- REQ-001: Parameter N, default 4: number of scores per vector; SHALL be ≥2.
- REQ-002: Parameter DW, default 16: signed Q8.8 word width for scores and weights.
- REQ-003: clk, input, 1: single clock; all state updates on the rising edge.
- REQ-004: rst, input, 1: synchronous, active-high reset.
- REQ-005: in_valid, input, 1: scores[] valid.
- REQ-006: in_ready, output, 1: block can accept scores; high only in IDLE.
- REQ-007: scores[N], input, signed DW each: Q8.8 attention scores.
- REQ-008: out_valid, output, 1: weights[] valid.
- REQ-009: out_ready, input, 1: consumer accepts weights.
- REQ-010: weights[N], output, signed DW each: Q8.8 softmax weights, range 0x0000..0x0100.

Function
- REQ-011: States SHALL be IDLE, MAX, EXP, DIV and DONE.
- REQ-012: In IDLE, an in_valid && in_ready edge SHALL register all scores[] and enter MAX; in_valid is ignored in every other state.
- REQ-013: MAX SHALL take N cycles, one element per cycle, and SHALL produce the signed maximum m.
- REQ-014: EXP SHALL take N cycles, one element per cycle.
  - d_i = m - s_i, unsigned, DW+1 bits.
  - Integer part di = d_i[DW:8]; fraction df = d_i[7:0].
  - e_i = (256 - (df>>1)) >> di; e_i = 0 when di ≥ 9.
  - e_i SHALL be stored; sum SHALL accumulate e_i, width DW+clog2(N) bits.
- REQ-015: The max element SHALL give e = 256, so sum ≥ 256 always.
- REQ-016: DIV SHALL use a restoring divider, 16 cycles per element, N elements in order.
  - weight_i = floor((e_i << 8) / sum), truncated.
  - Results SHALL land in weights[i] in registers.
- REQ-017: After the last DIV cycle, the state SHALL go to DONE with out_valid = 1.
  - out_valid SHALL rise exactly 18·N cycles after the accepting edge (72 for N=4).
- REQ-018: In DONE, weights[] and out_valid SHALL hold stable until out_ready = 1; that edge SHALL return the state to IDLE with out_valid = 0.
- REQ-019: Simultaneous out_ready in DONE and in_valid SHALL NOT accept new scores that cycle, because in_ready is low; acceptance happens no earlier than the next cycle.
- REQ-020: weights[] SHALL be zero-extended Q8.8, bits above bit 8 always 0.

Reset
- REQ-021: On rst = 1 at an edge, the state SHALL go to IDLE.
  - out_valid = 0, in_ready = 1, weights[] = 0.
  - Accumulator, max, divider and counters SHALL be cleared.
- REQ-022: Reset in any state, including mid-DIV, SHALL abort the operation with no partial output visible.
- REQ-023: rst SHALL have priority over in_valid and out_ready.

Configuration
- REQ-024: Macro SOFTMAX_LOG2E_EN.
  - Defined: in EXP, d_i SHALL first be scaled to d_i + (d_i>>1) - (d_i>>4), computed at DW+2 bits, giving an approximation of e^-d.
  - Undefined: no scaling; base-2 softmax 2^-d.
  - Latency SHALL be identical either way.

Verification
- REQ-025: Scores {0x0100×4} -> weights {0x0040×4}; out_valid exactly 72 cycles after accept; in_ready = 0 throughout.
- REQ-026: Scores {0x0200,0,0,0}:
  - Macro off -> {0x0092,0x0024,0x0024,0x0024}.
  - Macro on -> {0x00B4,0x0019,0x0019,0x0019}.
- REQ-027: Scores {0x0A00,0,0,0} -> {0x0100,0,0,0}; and {0xFF00,0xFF00,0xFF00,0xFF00} (negative) -> {0x0040×4}.
- REQ-028: out_ready held low 10 cycles in DONE -> weights and out_valid stable; in_valid pulses during that time ignored; out_ready = 1 -> IDLE next edge, in_ready = 1.
- REQ-029: rst pulsed at cycle 40 after accept (mid-DIV) -> next edge out_valid = 0, in_ready = 1, weights = 0; a subsequent vector completes correctly in 72 cycles.

Source files
------------

// File: rtl/softmax_seq_if.sv
// Handshake bundle for softmax_seq: a score vector in, a weight vector out.
interface softmax_seq_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] scores [N];
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] weights [N];

    modport master (
        output in_valid, scores, out_ready,
        input  in_ready, out_valid, weights
    );

    modport slave (
        input  in_valid, scores, out_ready,
        output in_ready, out_valid, weights
    );
endinterface

// File: rtl/softmax_seq.sv
// Sequential Q8.8 softmax: max search, piecewise exp2, restoring divide, N elements each.
// Define SOFTMAX_LOG2E_EN to scale d by ~log2(e) so the weights approximate e^-d instead of 2^-d.
module softmax_seq #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16
) (
    input logic          clk,
    input logic          rst,
    softmax_seq_if.slave bus
);
    localparam int unsigned SW = DW + $clog2(N);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
`ifdef SOFTMAX_LOG2E_EN
    localparam int unsigned XW = DW + 2;
`else
    localparam int unsigned XW = DW + 1;
`endif

    typedef enum logic [2:0] {StIdle, StMax, StExp, StDiv, StDone} state_e;

    state_e               state_q;
    logic signed [DW-1:0] s_q [N];
    logic signed [DW-1:0] m_q;
    logic [8:0]           e_q [N];
    logic [SW-1:0]        sum_q;
    logic [IW-1:0]        idx_q;
    logic [3:0]           step_q;
    logic [SW-1:0]        rem_q;
    logic [15:0]          dvd_q;
    logic signed [DW-1:0] w_q [N];
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [DW:0]    d;
    logic [XW-1:0]  x;
    logic [XW-9:0]  di;
    logic [7:0]     df;
    logic [8:0]     e_cur;
    logic [SW-1:0]  rem_cur;
    logic [15:0]    dvd_cur;
    logic [SW:0]    trial;
    logic [SW-1:0]  rem_nxt;
    logic [15:0]    dvd_nxt;

    // Exponent of the current element; m >= s always, so d is non-negative.
    always_comb begin
        d = {m_q[DW-1], m_q} - {s_q[idx_q][DW-1], s_q[idx_q]};
`ifdef SOFTMAX_LOG2E_EN
        x = XW'(d) + (XW'(d) >> 1) - (XW'(d) >> 4);
`else
        x = d;
`endif
        di = x[XW-1:8];
        df = x[7:0];
        e_cur = 9'd0;
        if (di < (XW-8)'(9)) begin
            e_cur = (9'd256 - {2'b00, df[7:1]}) >> di[3:0];
        end
    end

    // One restoring-divide step. The dividend is e<<8 (17 bits); bit 16 seeds the remainder
    // since sum >= 256 means that quotient bit is always zero.
    always_comb begin
        rem_cur = rem_q;
        dvd_cur = dvd_q;
        if (step_q == 4'd0) begin
            rem_cur = SW'(e_q[idx_q][8]);
            dvd_cur = {e_q[idx_q][7:0], 8'h00};
        end
        trial   = {rem_cur, dvd_cur[15]};
        rem_nxt = trial[SW-1:0];
        dvd_nxt = {dvd_cur[14:0], 1'b0};
        if (trial >= {1'b0, sum_q}) begin
            rem_nxt = SW'(trial - {1'b0, sum_q});
            dvd_nxt[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            step_q      <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            for (int i = 0; i < N; i++) begin
                s_q[i] <= '0;
                e_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        s_q        <= bus.scores;
                        in_ready_q <= 1'b0;
                        idx_q      <= '0;
                        state_q    <= StMax;
                    end
                end
                StMax: begin
                    if (idx_q == '0 || s_q[idx_q] > m_q) m_q <= s_q[idx_q];
                    if (idx_q == IW'(N - 1)) begin
                        idx_q   <= '0;
                        state_q <= StExp;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                StExp: begin
                    e_q[idx_q] <= e_cur;
                    sum_q      <= (idx_q == '0) ? SW'(e_cur) : sum_q + SW'(e_cur);
                    if (idx_q == IW'(N - 1)) begin
                        idx_q   <= '0;
                        step_q  <= '0;
                        state_q <= StDiv;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                StDiv: begin
                    rem_q  <= rem_nxt;
                    dvd_q  <= dvd_nxt;
                    step_q <= step_q + 4'd1;
                    if (step_q == 4'd15) begin
                        w_q[idx_q] <= DW'(dvd_nxt[8:0]);
                        if (idx_q == IW'(N - 1)) begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.weights   = w_q;
endmodule

// File: tb/tb_softmax_seq.sv
// Directed self-checking bench for softmax_seq with an expected-weights scoreboard.
module tb_softmax_seq;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [63:0] sb_q [$];

    softmax_seq_if #(.N(N), .DW(DW)) bus ();
    softmax_seq #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_weights(input string tag, input logic [63:0] exp);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_w%0d", tag, i), 32'(bus.weights[i]), 32'(exp[63-16*i -: 16]));
        end
    endtask

    // Drives one vector and returns just after the accepting edge.
    task automatic send(input logic [63:0] sc, input string tag);
        @(negedge clk);
        for (int i = 0; i < N; i++) bus.scores[i] = sc[63-16*i -: 16];
        check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input logic [63:0] sc, input logic [63:0] exp, input string tag,
                       input bit hold);
        int          lat;
        bit          ready_seen;
        logic [63:0] want;
        sb_q.push_back(exp);
        send(sc, tag);
        lat = 0;
        ready_seen = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
            if (bus.in_ready) ready_seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'd72);
        check({tag, "_in_ready_busy"}, 32'(ready_seen), 32'd0);
        want = sb_q.pop_front();
        check_weights(tag, want);
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                bus.in_valid = k[0];
                for (int i = 0; i < N; i++) bus.scores[i] = 16'sh0300;
                tick();
                check($sformatf("%s_hold%0d_valid", tag, k), 32'(bus.out_valid), 32'd1);
                check($sformatf("%s_hold%0d_ready", tag, k), 32'(bus.in_ready), 32'd0);
                check_weights($sformatf("%s_hold%0d", tag, k), want);
            end
            // in_valid stays high across the release edge: must not be taken that cycle
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            tick();
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            check({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
            tick();
            check({tag, "_no_accept"}, 32'(bus.in_ready), 32'd1);
        end else begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) bus.scores[i] = '0;
        repeat (2) tick();
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_weights("reset", 64'h0);
        @(negedge clk);
        rst = 1'b0;

        run(64'h0100_0100_0100_0100, 64'h0040_0040_0040_0040, "equal", 1'b0);
`ifdef SOFTMAX_LOG2E_EN
        run(64'h0200_0000_0000_0000, 64'h00B4_0019_0019_0019, "peak", 1'b1);
        run(64'h0000_0080_0100_0000, 64'h0029_0043_0069_0029, "mixed", 1'b0);
`else
        run(64'h0200_0000_0000_0000, 64'h0092_0024_0024_0024, "peak", 1'b1);
        run(64'h0000_0080_0100_0000, 64'h002E_0045_005D_002E, "mixed", 1'b0);
`endif
        run(64'h0A00_0000_0000_0000, 64'h0100_0000_0000_0000, "saturate", 1'b0);
        run(64'hFF00_FF00_FF00_FF00, 64'h0040_0040_0040_0040, "negative", 1'b0);

        // Abort mid-divide: reset lands on the 40th edge after accept.
        send(64'h0200_0000_0000_0000, "abort");
        repeat (39) tick();
        check("abort_pre_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check_weights("abort", 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run(64'h0100_0100_0100_0100, 64'h0040_0040_0040_0040, "after_abort", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
